alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Arbitrates a single shared 32-bit logic/arith unit (AND/OR/NOR/XOR/ADD/SUB/SLT/SLTU)
//   between two requesters in the Mini-MIPS datapath, e.g. the execute stage and the branch/address unit.
//   Round-robin grant. Operands are latched at grant. Results are registered and returned with a one-cycle done pulse.
//   Runs one op per 3 cycles. The op unit is internal, so requesters never drive it directly.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   OP_W   3   opcode width
// PORTS
//   clk      in   1      single clock, all state on rising edge
//   rst_n    in   1      synchronous reset, active low
//   req0     in   1      requester 0 wants an op; hold until gnt0
//   op0      in   OP_W   requester 0 opcode
//   a0, b0   in   WIDTH  requester 0 operands
//   req1     in   1      requester 1 wants an op; hold until gnt1
//   op1      in   OP_W   requester 1 opcode
//   a1, b1   in   WIDTH  requester 1 operands
//   gnt0     out  1      request 0 accepted this cycle (combinational, IDLE only)
//   gnt1     out  1      request 1 accepted this cycle (combinational, IDLE only)
//   done0    out  1      registered 1-cycle pulse: result belongs to requester 0
//   done1    out  1      registered 1-cycle pulse: result belongs to requester 1
//   result   out  WIDTH  registered result, valid while done0|done1
//   zero     out  1      result == 0, valid with done
//   ovf      out  1      signed overflow (ADD/SUB only, else 0), valid with done
//   busy     out  1      state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, prio=0 (req0 favoured), all latched operands=0.
//     done0=done1=result=zero=ovf=0. gnt0/gnt1 forced 0 while rst_n=0.
//   Reset mid-op: the op in flight is discarded and no done is issued. IDLE next cycle.
//   FSM IDLE -> EXEC -> RESP -> IDLE:
//     IDLE: if req0|req1, pick the winner, assert its gnt this cycle, and latch op/a/b/id.
//       Next state is EXEC. With no request, stay in IDLE.
//     EXEC: compute from the latched regs. Register result/zero/ovf and the done for id. Next state is RESP.
//     RESP: done_id=1 and result is stable. prio is set to the other requester (~id). Next state is IDLE.
//   Latency: gnt in cycle N, done high in cycle N+2. Next gnt possible in cycle N+3.
//   Arbitration:
//     Only one requester: that one wins.
//     Both requesting: prio wins.
//     prio toggles only on a completed op. prio does not change in cycles with no grant.
//   req seen in EXEC/RESP is ignored (no gnt). The requester keeps req held.
//   req dropped before gnt: no op. Operand changes after gnt have no effect.
//   Opcodes:
//     000 AND, 001 OR, 010 NOR, 011 XOR
//     100 ADD, 101 SUB (a-b), mod 2^WIDTH
//     110 SLT signed -> {0..,1}/0
//     111 SLTU unsigned -> {0..,1}/0
//   ovf:
//     ADD: sign(a)==sign(b) && sign(r)!=sign(a)
//     SUB: sign(a)!=sign(b) && sign(r)!=sign(a)
//     All other ops: 0.
//   result/zero/ovf hold their last value after done drops. Only done qualifies them.
// TESTING
//   1 Reset, then req0 NOR a=AAAAAAAA b=55555555 -> gnt0 at N, done0 at N+2, result=00000000, zero=1.
//   2 req0 ADD 7FFFFFFF+00000001 -> result 80000000, ovf=1. Then req1 SUB 0-1 -> FFFFFFFF, ovf=0, done1 only.
//   3 req0 SLT FFFFFFFF,00000001 -> 00000001. Then SLTU on the same operands -> 00000000, zero=1.
//   4 After reset, req0 and req1 held together for 6 ops -> gnt order 0,1,0,1,0,1.
//     Each gnt is 3 cycles apart, and there is never a dual gnt or a dual done.
//   5 req1 asserted during EXEC of a req0 op -> no gnt1 until IDLE. gnt1 at N+3. result0 is unaffected.
//   6 rst_n low for 1 cycle during EXEC -> busy=0 next cycle, no done pulse, and the next dual request grants req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one 32-bit logic/arith unit between two requesters.
// One op per three cycles: grant (IDLE), compute (EXEC), respond with done pulse (RESP).
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [OP_W-1:0]  op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [OP_W-1:0]  op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  logic             pick1;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic             sltu;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;

  // prio_q = 0 favours requester 0 when both ask in the same cycle
  assign pick1 = req1 && (!req0 || prio_q);

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign slt  = $signed(a_q) < $signed(b_q);
  assign sltu = a_q < b_q;

  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (op_q)
      OP_AND:  alu_r = a_q & b_q;
      OP_OR:   alu_r = a_q | b_q;
      OP_NOR:  alu_r = ~(a_q | b_q);
      OP_XOR:  alu_r = a_q ^ b_q;
      OP_ADD: begin
        alu_r = sum;
        alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff;
        alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, sltu};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (req0 || req1)) begin
          gnt0    = !pick1;
          gnt1    = pick1;
          id_d    = pick1;
          op_d    = pick1 ? op1 : op0;
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_r;
        zero_d   = (alu_r == '0);
        ovf_d    = alu_v;
        done0_d  = !id_q;
        done1_d  = id_q;
        state_d  = RESP;
      end
      RESP: begin
        // Only a completed op hands priority to the other requester
        prio_d  = !id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model (free every 3 cycles, round-robin, plain-arithmetic ALU).
module tb_alu_share_arbiter;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  typedef struct {
    int          cyc;
    bit          id;
    logic [31:0] r;
    bit          z;
    bit          v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, zero, ovf, busy;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  bit m_prio = 1'b0;
  int gnt_cyc_log[$];
  bit gnt_id_log[$];

  alu_share_arbiter #(.WIDTH(32), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ALU from the opcode table; overflow judged by whether the true sum fits in 32 signed bits
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = 1'b0;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_ADD:  begin s = sa + sb; r = a + b; v = (s > MAX_S) || (s < MIN_S); end
      OP_SUB:  begin s = sa - sb; r = a - b; v = (s > MAX_S) || (s < MIN_S); end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [4];
    corners = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    advance();
    advance();
    rst_n = 1'b1;
    m_prio = 1'b0;
  endtask

  // Runs one op from a single requester and checks grant, latency, result and hold behaviour
  task automatic single_op(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r_obs, output logic z_obs, output logic v_obs);
    logic [31:0] er;
    logic ev;
    int wait_c;
    ref_alu(op, a, b, er, ev);
    r_obs = 'x; z_obs = 'x; v_obs = 'x;
    req0 = !id; req1 = id;
    if (id) begin op1 = op; a1 = a; b1 = b; end
    else begin op0 = op; a0 = a; b0 = b; end
    wait_c = 0;
    @(negedge clk);
    while (!(id ? gnt1 : gnt0) && wait_c < 8) begin
      advance();
      @(negedge clk);
      wait_c++;
    end
    vectors++;
    if ((id ? gnt1 : gnt0) !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL op_gnt%0d: got 0 expected 1 within 8 cycles", id);
      req0 = 1'b0; req1 = 1'b0;
      advance();
      return;
    end
    vectors++;
    if ((id ? gnt0 : gnt1) !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL op_other_gnt: got 1 expected 0 (id %0d)", id);
    end
    advance();
    req0 = 1'b0; req1 = 1'b0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
    @(negedge clk);
    vectors++;
    if ({busy, done0, done1} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL op_exec: busy/done0/done1 got %b expected 100", {busy, done0, done1});
    end
    advance();
    @(negedge clk);
    vectors++;
    if ({done0, done1} !== {!id, id}) begin
      miscompares++;
      $display("[TB] FAIL op_done: done0/done1 got %b expected %b", {done0, done1}, {!id, id});
    end
    vectors++;
    if ({result, zero, ovf} !== {er, (er == 32'd0), ev}) begin
      miscompares++;
      $display("[TB] FAIL op_result: got %h z%b v%b expected %h z%b v%b", result, zero, ovf, er, (er == 32'd0), ev);
    end
    r_obs = result; z_obs = zero; v_obs = ovf;
    advance();
    @(negedge clk);
    vectors++;
    if ({busy, done0, done1, result} !== {3'b000, er}) begin
      miscompares++;
      $display("[TB] FAIL op_hold: busy/done %b result %h expected 000 %h", {busy, done0, done1}, result, er);
    end
    advance();
  endtask

  // Cycle-stepped traffic against the model; both=1 holds both requests for the whole window
  task automatic run_traffic(input int ncyc, input bit both);
    exp_t q[$];
    exp_t e;
    int wait_c;
    bit eg0, eg1, win, eb;
    logic [31:0] er;
    logic ev;
    wait_c = 0;
    win = 1'b0;
    for (int c = 0; c < ncyc + 3; c++) begin
      if (c < ncyc) begin
        req0 = both ? 1'b1 : ($urandom_range(0, 2) != 0);
        req1 = both ? 1'b1 : ($urandom_range(0, 2) != 0);
        op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
        a0 = rand_operand(); b0 = rand_operand();
        a1 = rand_operand(); b1 = rand_operand();
      end else begin
        req0 = 1'b0; req1 = 1'b0;
      end
      if (wait_c > 0) wait_c--;
      eb = (wait_c > 0);
      eg0 = 1'b0; eg1 = 1'b0;
      if (wait_c == 0 && (req0 || req1)) begin
        win = (req0 && req1) ? m_prio : req1;
        eg0 = !win; eg1 = win;
      end
      @(negedge clk);
      vectors++;
      if ({gnt0, gnt1} !== {eg0, eg1}) begin
        miscompares++;
        $display("[TB] FAIL traffic_gnt c%0d: got %b expected %b", c, {gnt0, gnt1}, {eg0, eg1});
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("[TB] FAIL traffic_busy c%0d: got %b expected %b", c, busy, eb);
      end
      if (eg0 || eg1) begin
        ref_alu(win ? op1 : op0, win ? a1 : a0, win ? b1 : b0, er, ev);
        e = '{cyc: c + 2, id: win, r: er, z: (er == 32'd0), v: ev};
        q.push_back(e);
        gnt_cyc_log.push_back(c);
        gnt_id_log.push_back(win);
        wait_c = 3;
        m_prio = !win;
      end
      if (q.size() > 0 && q[0].cyc == c) begin
        e = q.pop_front();
        vectors++;
        if ({done0, done1} !== {!e.id, e.id}) begin
          miscompares++;
          $display("[TB] FAIL traffic_done c%0d: got %b expected %b", c, {done0, done1}, {!e.id, e.id});
        end
        vectors++;
        if ({result, zero, ovf} !== {e.r, e.z, e.v}) begin
          miscompares++;
          $display("[TB] FAIL traffic_result c%0d: got %h z%b v%b expected %h z%b v%b",
                   c, result, zero, ovf, e.r, e.z, e.v);
        end
      end else begin
        vectors++;
        if ({done0, done1} !== 2'b00) begin
          miscompares++;
          $display("[TB] FAIL traffic_nodone c%0d: got %b expected 00", c, {done0, done1});
        end
      end
      advance();
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL traffic_drain: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'h1234_5678; b0 = 32'h1111_1111;
    advance();
    advance();
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_gnt: got %b expected 00", {gnt0, gnt1});
    end
    vectors++;
    if ({busy, done0, done1, zero, ovf, result} !== {5'b00000, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: busy/done0/done1/zero/ovf %b result %h expected 00000 00000000",
               {busy, done0, done1, zero, ovf}, result);
    end
    rst_n = 1'b1;
    req0 = 1'b0;
    m_prio = 1'b0;
    advance();
  endtask

  task automatic test_nor();
    logic [31:0] r; logic z, v;
    single_op(1'b0, OP_NOR, 32'hAAAA_AAAA, 32'h5555_5555, r, z, v);
    vectors++;
    if ({r, z} !== {32'h0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL nor_zero: got %h z%b expected 00000000 z1", r, z);
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] r; logic z, v;
    single_op(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, r, z, v);
    vectors++;
    if ({r, v} !== {32'h8000_0000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL add_ovf: got %h v%b expected 80000000 v1", r, v);
    end
    single_op(1'b1, OP_SUB, 32'h0000_0000, 32'h0000_0001, r, z, v);
    vectors++;
    if ({r, v} !== {32'hFFFF_FFFF, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL sub_neg: got %h v%b expected ffffffff v0", r, v);
    end
  endtask

  task automatic test_compare();
    logic [31:0] r; logic z, v;
    single_op(1'b0, OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, r, z, v);
    vectors++;
    if (r !== 32'h0000_0001) begin
      miscompares++;
      $display("[TB] FAIL slt: got %h expected 00000001", r);
    end
    single_op(1'b0, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, r, z, v);
    vectors++;
    if ({r, z} !== {32'h0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL sltu: got %h z%b expected 00000000 z1", r, z);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gnt_cyc_log.delete();
    gnt_id_log.delete();
    run_traffic(18, 1'b1);
    vectors++;
    if (gnt_id_log.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d grants expected 6", gnt_id_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (gnt_id_log[i] !== 1'(i % 2) || gnt_cyc_log[i] != 3 * i) begin
          miscompares++;
          $display("[TB] FAIL b2b_order[%0d]: got id%0d cyc%0d expected id%0d cyc%0d",
                   i, gnt_id_log[i], gnt_cyc_log[i], i % 2, 3 * i);
        end
      end
    end
  endtask

  task automatic test_exec_overlap();
    logic [31:0] er0, er1;
    logic ev0, ev1;
    req0 = 1'b1; req1 = 1'b0; op0 = OP_ADD; a0 = 32'h8000_0000; b0 = 32'hFFFF_FFFF;
    ref_alu(op0, a0, b0, er0, ev0);
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL ovl_gnt0: got %b expected 10", {gnt0, gnt1});
    end
    advance();
    req0 = 1'b0; req1 = 1'b1; op1 = OP_XOR; a1 = 32'hDEAD_BEEF; b1 = 32'h0F0F_0F0F;
    ref_alu(op1, a1, b1, er1, ev1);
    @(negedge clk);
    vectors++;
    if ({gnt1, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL ovl_exec: gnt1/busy got %b expected 01", {gnt1, busy});
    end
    advance();
    @(negedge clk);
    vectors++;
    if ({gnt1, done0, result, ovf} !== {2'b01, er0, ev0}) begin
      miscompares++;
      $display("[TB] FAIL ovl_resp: gnt1 %b done0 %b result %h v%b expected 0 1 %h v%b",
               gnt1, done0, result, ovf, er0, ev0);
    end
    advance();
    @(negedge clk);
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL ovl_gnt1: got %b expected 01 at N+3", {gnt0, gnt1});
    end
    advance();
    req1 = 1'b0;
    advance();
    @(negedge clk);
    vectors++;
    if ({done0, done1, result} !== {2'b01, er1}) begin
      miscompares++;
      $display("[TB] FAIL ovl_done1: done %b result %h expected 01 %h", {done0, done1}, result, er1);
    end
    advance();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r, er;
    logic z, v, ev;
    single_op(1'b0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, r, z, v);
    req1 = 1'b1; op1 = OP_OR; a1 = 32'h1; b1 = 32'h2;
    @(negedge clk);
    vectors++;
    if (gnt1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rmid_gnt1: got %b expected 1", gnt1);
    end
    advance();
    req1 = 1'b0;
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    op0 = OP_ADD; a0 = 32'h0000_0010; b0 = 32'h0000_0020;
    op1 = OP_SUB; a1 = 32'h5; b1 = 32'h3;
    ref_alu(op0, a0, b0, er, ev);
    @(negedge clk);
    vectors++;
    if ({busy, done0, done1} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rmid_idle: busy/done0/done1 got %b expected 000", {busy, done0, done1});
    end
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rmid_prio: got %b expected 10", {gnt0, gnt1});
    end
    advance();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done0, done1} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rmid_nodone: got %b expected 00", {done0, done1});
    end
    advance();
    @(negedge clk);
    vectors++;
    if ({done0, done1, result} !== {2'b10, er}) begin
      miscompares++;
      $display("[TB] FAIL rmid_result: done %b result %h expected 10 %h", {done0, done1}, result, er);
    end
    advance();
    advance();
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(400, 1'b0);
  endtask

  initial begin
    $display("[TB] starting alu_share_arbiter bench");
    test_reset();
    test_nor();
    test_add_sub();
    test_compare();
    test_back_to_back();
    test_exec_overlap();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
